// File: rtl/bcd_down_timer.sv
// Cascaded multi-digit BCD down-counter for the cook timer. It includes a tick
// prescaler, an mm:ss mode, clamping of loaded digits and a done pulse.
`timescale 1ns/1ps

module bcd_down_digit #(
    parameter logic [3:0] MAXV = 4'd9
) (
    input  logic [3:0] din,
    input  logic [3:0] cur,
    input  logic       dec_en,
    output logic [3:0] ld_val,
    output logic       clamp,
    output logic [3:0] dec_val,
    output logic       is_zero
);

    always_comb begin
        clamp   = (din > MAXV);
        ld_val  = clamp ? MAXV : din;
        is_zero = (cur == 4'd0);
        dec_val = cur;
        if (dec_en) begin
            dec_val = is_zero ? MAXV : cur - 4'd1;
        end
    end

endmodule

module bcd_down_timer #(
    parameter int DIGITS   = 4,
    parameter int MINSEC   = 1,
    parameter int TICK_DIV = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  loadn,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   count,
    output logic                  zero,
    output logic                  tc,
    output logic                  done,
    output logic                  load_err
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [DIGITS-1:0][3:0] count_q, count_d;
    logic [DIGITS-1:0][3:0] load_val, dec_val;
    logic [DIGITS-1:0]      clamp_err, dig_zero, borrow;
    logic [PW-1:0]          pre_q, pre_d;
    logic                   done_q, done_d;
    logic                   load_err_q, load_err_d;
    logic                   tick;

    assign zero     = &dig_zero;
    assign tc       = zero & en;
    assign count    = count_q;
    assign done     = done_q;
    assign load_err = load_err_q;

    // A tick only happens while running and nonzero, so the chain never
    // borrows out of the top digit (no wrap to all-max).
    assign tick = loadn & en & ~zero & (pre_q == PRE_MAX);

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        localparam logic [3:0] MAXV = (MINSEC != 0 && g == 1) ? 4'd5 : 4'd9;

        if (g == 0) begin : g_b0
            assign borrow[g] = tick;
        end else begin : g_bn
            assign borrow[g] = borrow[g-1] & dig_zero[g-1];
        end

        bcd_down_digit #(.MAXV(MAXV)) u_dig (
            .din     (data[4*g +: 4]),
            .cur     (count_q[g]),
            .dec_en  (borrow[g]),
            .ld_val  (load_val[g]),
            .clamp   (clamp_err[g]),
            .dec_val (dec_val[g]),
            .is_zero (dig_zero[g])
        );
    end

    always_comb begin
        count_d    = count_q;
        pre_d      = pre_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        if (!loadn) begin
            count_d    = load_val;
            pre_d      = '0;
            load_err_d = |clamp_err;
        end else if (en && !zero) begin
            if (tick) begin
                pre_d   = '0;
                count_d = dec_val;
                done_d  = (dec_val == '0);
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q    <= '0;
            pre_q      <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            pre_q      <= pre_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer using three instances: mm:ss with
// TICK_DIV=1, mm:ss with TICK_DIV=4, and decimal with TICK_DIV=1.
`timescale 1ns/1ps

module tb_bcd_down_timer;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] d1_data, d4_data, d0_data;
    logic        d1_loadn, d4_loadn, d0_loadn;
    logic        d1_en, d4_en, d0_en;
    logic [15:0] c1, c4, c0;
    logic        z1, z4, z0, t1, t4, t0, dn1, dn4, dn0, e1, e4, e0;

    int total = 0;
    int bad   = 0;

    bcd_down_timer #(.DIGITS(4), .MINSEC(1), .TICK_DIV(1)) u_d1 (
        .clk(clk), .clr(clr), .data(d1_data), .loadn(d1_loadn), .en(d1_en),
        .count(c1), .zero(z1), .tc(t1), .done(dn1), .load_err(e1));

    bcd_down_timer #(.DIGITS(4), .MINSEC(1), .TICK_DIV(4)) u_d4 (
        .clk(clk), .clr(clr), .data(d4_data), .loadn(d4_loadn), .en(d4_en),
        .count(c4), .zero(z4), .tc(t4), .done(dn4), .load_err(e4));

    bcd_down_timer #(.DIGITS(4), .MINSEC(0), .TICK_DIV(1)) u_d0 (
        .clk(clk), .clr(clr), .data(d0_data), .loadn(d0_loadn), .en(d0_en),
        .count(c0), .zero(z0), .tc(t0), .done(dn0), .load_err(e0));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] data;
        logic        loadn;
        logic        en;
        logic [15:0] exp_cnt;
        logic        exp_zero;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vt[19];

    initial begin
        vt[0]  = '{16'h0101, 1'b0, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{16'h0000, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{16'h0000, 1'b1, 1'b1, 16'h0059, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{16'h0000, 1'b1, 1'b1, 16'h0058, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{16'h0F7C, 1'b0, 1'b0, 16'h0959, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{16'h0000, 1'b1, 1'b0, 16'h0959, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{16'h0959, 1'b0, 1'b0, 16'h0959, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
        vt[9]  = '{16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
        vt[10] = '{16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
        vt[11] = '{16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
        vt[12] = '{16'h1000, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vt[13] = '{16'h0000, 1'b1, 1'b1, 16'h0959, 1'b0, 1'b0, 1'b0};
        vt[14] = '{16'h00A0, 1'b0, 1'b0, 16'h0050, 1'b0, 1'b0, 1'b1};
        vt[15] = '{16'h0060, 1'b0, 1'b0, 16'h0050, 1'b0, 1'b0, 1'b1};
        vt[16] = '{16'h0050, 1'b0, 1'b1, 16'h0050, 1'b0, 1'b0, 1'b0};
        vt[17] = '{16'h0000, 1'b1, 1'b1, 16'h0049, 1'b0, 1'b0, 1'b0};
        vt[18] = '{16'h0123, 1'b0, 1'b1, 16'h0123, 1'b0, 1'b0, 1'b0};

        d1_data = '0; d4_data = '0; d0_data = '0;
        d1_loadn = 1'b1; d4_loadn = 1'b1; d0_loadn = 1'b1;
        d1_en = 1'b1; d4_en = 1'b0; d0_en = 1'b0;

        // Reset state while clr is held
        step();
        step();
        chk("rst_count1", c1, 16'h0000);
        chk("rst_count4", c4, 16'h0000);
        chk("rst_count0", c0, 16'h0000);
        chk("rst_zero", {13'd0, z1, z4, z0}, 16'h0007);
        chk("rst_done_err", {10'd0, dn1, dn4, dn0, e1, e4, e0}, 16'h0000);
        chk("rst_tc_en1", {15'd0, t1}, 16'h0001);
        chk("rst_tc_en0", {14'd0, t4, t0}, 16'h0000);
        clr = 1'b0;
        d1_en = 1'b0;

        // Asynchronous clear between clock edges
        d1_data = 16'h0130; d1_loadn = 1'b0;
        step();
        chk("pre_clr_count", c1, 16'h0130);
        d1_loadn = 1'b1;
        #2 clr = 1'b1;
        #1;
        chk("async_clr_count", c1, 16'h0000);
        chk("async_clr_zero", {15'd0, z1}, 16'h0001);
        chk("async_clr_done", {15'd0, dn1}, 16'h0000);
        #1 clr = 1'b0;
        step();

        for (int i = 0; i < 19; i++) begin
            d1_data  = vt[i].data;
            d1_loadn = vt[i].loadn;
            d1_en    = vt[i].en;
            step();
            chk($sformatf("vec%0d_count", i), c1, vt[i].exp_cnt);
            chk($sformatf("vec%0d_zero", i), {15'd0, z1}, {15'd0, vt[i].exp_zero});
            chk($sformatf("vec%0d_tc", i), {15'd0, t1}, {15'd0, vt[i].exp_zero & vt[i].en});
            chk($sformatf("vec%0d_done", i), {15'd0, dn1}, {15'd0, vt[i].exp_done});
            chk($sformatf("vec%0d_err", i), {15'd0, e1}, {15'd0, vt[i].exp_err});
        end
        d1_loadn = 1'b1; d1_en = 1'b0;

        // Prescaler by 4: 0002 -> 0001 after 4 cycles, 0000 after 8 cycles
        d4_data = 16'h0002; d4_loadn = 1'b0; d4_en = 1'b0;
        step();
        d4_loadn = 1'b1; d4_en = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            chk($sformatf("div4_c%0d_count", c), c4,
                (c < 4) ? 16'h0002 : (c < 8) ? 16'h0001 : 16'h0000);
            chk($sformatf("div4_c%0d_done", c), {15'd0, dn4}, (c == 8) ? 16'h0001 : 16'h0000);
        end
        chk("div4_hold_tc", {15'd0, t4}, 16'h0001);

        // Pause mid-prescale and resume without losing the partial tick
        d4_data = 16'h0005; d4_loadn = 1'b0; d4_en = 1'b0;
        step();
        d4_loadn = 1'b1; d4_en = 1'b1;
        step();
        step();
        chk("pause_pre", c4, 16'h0005);
        d4_en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("pause_c%0d_count", c), c4, 16'h0005);
        end
        d4_en = 1'b1;
        step();
        chk("resume1_count", c4, 16'h0005);
        step();
        chk("resume2_count", c4, 16'h0004);
        d4_en = 1'b0;

        // Decimal mode: tens digit wraps to 9
        d0_data = 16'h0100; d0_loadn = 1'b0; d0_en = 1'b1;
        step();
        chk("dec_load", c0, 16'h0100);
        d0_loadn = 1'b1;
        step();
        chk("dec_tick1", c0, 16'h0099);
        step();
        chk("dec_tick2", c0, 16'h0098);
        d0_loadn = 1'b0;
        step();
        chk("dec_load_wins", c0, 16'h0100);
        d0_data = 16'h0F7C;
        step();
        chk("dec_clamp_count", c0, 16'h0979);
        chk("dec_clamp_err", {15'd0, e0}, 16'h0001);
        d0_loadn = 1'b1; d0_en = 1'b0;
        step();
        chk("dec_err_pulse", {15'd0, e0}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
